// File: rtl/alu_seq_pkg.sv
// Shared definitions for the multi-cycle decimal ALU: op codes, FSM states,
// error fill values and the double-dabble digit adjust helper.
package alu_seq_pkg;

    localparam logic [1:0] OP_SUM = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        CONV = 2'b10,
        DONE = 2'b11
    } state_t;

    // Result bit fill and BCD digit fill used for divide errors
    localparam logic       RES_ERR_BIT   = 1'b1;
    localparam logic [3:0] BCD_ERR_DIGIT = 4'hF;

    localparam logic [3:0] DABBLE_THRESH = 4'd5;
    localparam logic [3:0] DABBLE_ADD    = 4'd3;

    // Double-dabble pre-shift correction of one BCD digit
    function automatic logic [3:0] dabble_adj(input logic [3:0] d);
        return (d >= DABBLE_THRESH) ? 4'(d + DABBLE_ADD) : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (double dabble), one bit per cycle.
// The load edge already performs the first shift (the adjust step on an
// all-zero digit field is a no-op), so WIDTH_IN shifts finish on the
// WIDTH_IN-th edge counted from and including the start edge; done pulses
// for the cycle after the last shift and bcd holds until the next start.
module bin2bcd_seq #(
    parameter int unsigned WIDTH_IN = 16,
    parameter int unsigned DIGITS   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH_IN-1:0]   bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);
    import alu_seq_pkg::*;

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH_IN + 1);

    logic [WIDTH_IN-1:0] bin_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [BCD_W-1:0]    adj_c;

    // Add 3 to every digit >= 5 ahead of the shift
    always_comb begin
        adj_c = bcd;
        for (int i = 0; i < int'(DIGITS); i++) begin
            adj_c[4*i +: 4] = dabble_adj(bcd[4*i +: 4]);
        end
    end

    // Load-with-first-shift, then shift one bit per cycle until all bits consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                bcd   <= BCD_W'(bin[WIDTH_IN-1]);
                bin_q <= bin << 1;
                cnt_q <= CNT_W'(1);
                busy  <= 1'b1;
            end else if (busy) begin
                {bcd, bin_q} <= {adj_c, bin_q} << 1;
                cnt_q        <= cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH_IN - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle decimal ALU: SUM/SUB in one cycle, shift-add MUL and restoring
// DIV one bit per cycle, then an iterative binary-to-BCD conversion.
// Build option ALU_SEQ_DIV_EN: when undefined the divider is not built and
// every DIV request returns the divide-error response.
module alu_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      in1,
    input  logic [WIDTH-1:0]      in2,
    input  logic [1:0]            op,
    output logic                  ready,
    output logic                  done,
    output logic [2*WIDTH-1:0]    result,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  zero,
    output logic                  error
);
    import alu_seq_pkg::*;

    localparam int unsigned RES_W = 2 * WIDTH;
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t state_q, state_d;

    logic [WIDTH-1:0] in1_q, in2_q;
    logic [1:0]       op_q;
    logic             err_q;
    logic [RES_W-1:0] res_q;
    logic [CNT_W-1:0] cnt_q;

    logic [RES_W-1:0] acc_q, mcand_q;
    logic [WIDTH-1:0] mplr_q;

    logic             accept_c, err_c, calc_last_c, conv_start_c;
    logic [RES_W-1:0] prod_nxt_c, calc_res_c;

    logic             conv_busy, conv_done;
    logic [BCD_W-1:0] conv_bcd;

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH:0]   rem_sh_c, rem_nxt_c;
    logic [WIDTH-1:0] quo_nxt_c;

    // One restoring-division step: shift in next dividend bit, subtract if it fits
    always_comb begin
        rem_sh_c  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        rem_nxt_c = rem_sh_c;
        quo_nxt_c = quo_q << 1;
        if (rem_sh_c >= {1'b0, in2_q}) begin
            rem_nxt_c = rem_sh_c - {1'b0, in2_q};
            quo_nxt_c = (quo_q << 1) | WIDTH'(1);
        end
    end
`endif

    // Request acceptance and error classification of the incoming request
    always_comb begin
        accept_c = (state_q == IDLE) && ready && start;
        err_c    = (op == OP_SUB) && (in1 < in2);
`ifdef ALU_SEQ_DIV_EN
        if ((op == OP_DIV) && (in2 == '0)) err_c = 1'b1;
`else
        if (op == OP_DIV) err_c = 1'b1;
`endif
    end

    // Arithmetic result as it will stand after the current CALC edge
    always_comb begin
        prod_nxt_c  = acc_q + (mplr_q[0] ? mcand_q : '0);
        calc_last_c = (op_q == OP_SUM) || (op_q == OP_SUB) ||
                      (cnt_q == CNT_W'(WIDTH - 1));
        calc_res_c  = '0;
        case (op_q)
            OP_SUM:  calc_res_c = RES_W'(in1_q) + RES_W'(in2_q);
            OP_SUB:  calc_res_c = RES_W'(in1_q - in2_q);
            OP_MUL:  calc_res_c = prod_nxt_c;
`ifdef ALU_SEQ_DIV_EN
            OP_DIV:  calc_res_c = RES_W'(quo_nxt_c);
`endif
            default: calc_res_c = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state and converter launch
    always_comb begin
        state_d      = state_q;
        conv_start_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c) state_d = err_c ? DONE : CALC;
            end
            CALC: begin
                if (calc_last_c && !conv_busy) begin
                    state_d      = CONV;
                    conv_start_c = 1'b1;
                end
            end
            CONV: begin
                if (conv_done) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, iterative datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready   <= 1'b1;
            done    <= 1'b0;
            result  <= '0;
            bcd     <= '0;
            zero    <= 1'b0;
            error   <= 1'b0;
            in1_q   <= '0;
            in2_q   <= '0;
            op_q    <= OP_SUM;
            err_q   <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
`ifdef ALU_SEQ_DIV_EN
            rem_q   <= '0;
            quo_q   <= '0;
`endif
        end else begin
            done <= (state_q == DONE);

            if (accept_c) begin
                ready   <= 1'b0;
                in1_q   <= in1;
                in2_q   <= in2;
                op_q    <= op;
                err_q   <= err_c;
                cnt_q   <= '0;
                acc_q   <= '0;
                mcand_q <= RES_W'(in1);
                mplr_q  <= in2;
`ifdef ALU_SEQ_DIV_EN
                rem_q   <= '0;
                quo_q   <= in1;
`endif
                if (err_c) begin
                    res_q <= (op == OP_SUB) ? '0 : {RES_W{RES_ERR_BIT}};
                end
            end else if (done) begin
                ready <= 1'b1;
            end

            // Iterate while more bits remain; the final step is taken via calc_res_c
            if ((state_q == CALC) && !calc_last_c) begin
                cnt_q   <= cnt_q + CNT_W'(1);
                acc_q   <= prod_nxt_c;
                mcand_q <= mcand_q << 1;
                mplr_q  <= mplr_q >> 1;
`ifdef ALU_SEQ_DIV_EN
                rem_q   <= rem_nxt_c;
                quo_q   <= quo_nxt_c;
`endif
            end

            if (conv_start_c) res_q <= calc_res_c;

            if (state_q == DONE) begin
                result <= res_q;
                zero   <= (res_q == '0);
                error  <= err_q;
                if (err_q) bcd <= (op_q == OP_SUB) ? '0 : {DIGITS{BCD_ERR_DIGIT}};
                else       bcd <= conv_bcd;
            end
        end
    end

    bin2bcd_seq #(
        .WIDTH_IN (RES_W),
        .DIGITS   (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start_c),
        .bin   (calc_res_c),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8, DIGITS=5.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  in1, in2;
    logic [1:0]  op;
    logic        ready, done, zero, error;
    logic [15:0] result;
    logic [19:0] bcd;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    int saw;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8), .DIGITS(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .in1    (in1),
        .in2    (in2),
        .op     (op),
        .ready  (ready),
        .done   (done),
        .result (result),
        .bcd    (bcd),
        .zero   (zero),
        .error  (error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, optionally poke start mid-operation, measure latency
    task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                          input bit poke, output int l);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        op = o; in1 = a; in2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ready_fall", 32'(ready), 32'd0);
        l = 0;
        while (!done && l < 100) begin
            @(posedge clk); #1;
            l++;
            if (poke && l == 4) begin
                start = 1'b1; op = 2'b00; in1 = 8'd1; in2 = 8'd1;
            end else if (poke && l == 6) begin
                start = 1'b0;
            end
        end
        check("done_seen", 32'(done), 32'd1);
        check("ready_at_done", 32'(ready), 32'd0);
        @(posedge clk); #1;
        check("done_pulse_end", 32'(done), 32'd0);
        check("ready_rise", 32'(ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; in1 = '0; in2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  32'(ready),  32'd1);
        check("rst_done",   32'(done),   32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_bcd",    32'(bcd),    32'd0);
        check("rst_zero",   32'(zero),   32'd0);
        check("rst_error",  32'(error),  32'd0);
        @(negedge clk) rst_n = 1'b1;

        // SUM 200+255
        run_op(2'b00, 8'd200, 8'd255, 1'b0, lat);
        check("sum_res",  32'(result), 32'd455);
        check("sum_bcd",  32'(bcd),    32'h00455);
        check("sum_zero", 32'(zero),   32'd0);
        check("sum_err",  32'(error),  32'd0);
        check("sum_lat",  32'(lat),    32'd18);

        // MUL 200*255
        run_op(2'b10, 8'd200, 8'd255, 1'b0, lat);
        check("mul_res", 32'(result), 32'd51000);
        check("mul_bcd", 32'(bcd),    32'h51000);
        check("mul_err", 32'(error),  32'd0);
        check("mul_lat", 32'(lat),    32'd25);

        // MUL max operands
        run_op(2'b10, 8'd255, 8'd255, 1'b0, lat);
        check("mulmax_res", 32'(result), 32'd65025);
        check("mulmax_bcd", 32'(bcd),    32'h65025);
        check("mulmax_lat", 32'(lat),    32'd25);

        // SUB underflow error
        run_op(2'b01, 8'd3, 8'd7, 1'b0, lat);
        check("suberr_err",  32'(error),  32'd1);
        check("suberr_zero", 32'(zero),   32'd1);
        check("suberr_res",  32'(result), 32'd0);
        check("suberr_bcd",  32'(bcd),    32'd0);
        check("suberr_lat",  32'(lat),    32'd1);

        // SUB equal operands
        run_op(2'b01, 8'd7, 8'd7, 1'b0, lat);
        check("subeq_zero", 32'(zero),   32'd1);
        check("subeq_err",  32'(error),  32'd0);
        check("subeq_res",  32'(result), 32'd0);
        check("subeq_lat",  32'(lat),    32'd18);

        // SUB normal
        run_op(2'b01, 8'd250, 8'd13, 1'b0, lat);
        check("sub_res", 32'(result), 32'd237);
        check("sub_bcd", 32'(bcd),    32'h00237);

        // DIV 100/7
        run_op(2'b11, 8'd100, 8'd7, 1'b0, lat);
`ifdef ALU_SEQ_DIV_EN
        check("div_res",  32'(result), 32'd14);
        check("div_bcd",  32'(bcd),    32'h00014);
        check("div_err",  32'(error),  32'd0);
        check("div_lat",  32'(lat),    32'd25);
`else
        check("div_res",  32'(result), 32'hFFFF);
        check("div_bcd",  32'(bcd),    32'hFFFFF);
        check("div_err",  32'(error),  32'd1);
        check("div_lat",  32'(lat),    32'd1);
`endif

        // DIV 255/1
        run_op(2'b11, 8'd255, 8'd1, 1'b0, lat);
`ifdef ALU_SEQ_DIV_EN
        check("div1_res", 32'(result), 32'd255);
        check("div1_bcd", 32'(bcd),    32'h00255);
`else
        check("div1_res", 32'(result), 32'hFFFF);
        check("div1_bcd", 32'(bcd),    32'hFFFFF);
`endif

        // DIV by zero
        run_op(2'b11, 8'd255, 8'd0, 1'b0, lat);
        check("div0_err",  32'(error),  32'd1);
        check("div0_res",  32'(result), 32'hFFFF);
        check("div0_bcd",  32'(bcd),    32'hFFFFF);
        check("div0_zero", 32'(zero),   32'd0);
        check("div0_lat",  32'(lat),    32'd1);

        // start pulsed while busy is ignored
        run_op(2'b10, 8'd12, 8'd34, 1'b1, lat);
        check("ign_res", 32'(result), 32'd408);
        check("ign_bcd", 32'(bcd),    32'h00408);
        check("ign_lat", 32'(lat),    32'd25);
        saw = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) saw++;
        end
        check("ign_no_queue", 32'(saw), 32'd0);

        // Reset in the middle of a MUL
        @(negedge clk);
        op = 2'b10; in1 = 8'd200; in2 = 8'd255; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_ready",  32'(ready),  32'd1);
        check("mrst_done",   32'(done),   32'd0);
        check("mrst_result", 32'(result), 32'd0);
        check("mrst_bcd",    32'(bcd),    32'd0);
        check("mrst_zero",   32'(zero),   32'd0);
        check("mrst_error",  32'(error),  32'd0);
        @(negedge clk) rst_n = 1'b1;
        saw = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw++;
        end
        check("mrst_no_done", 32'(saw), 32'd0);

        // Recovery: SUM 0+0
        run_op(2'b00, 8'd0, 8'd0, 1'b0, lat);
        check("sum0_res",  32'(result), 32'd0);
        check("sum0_zero", 32'(zero),   32'd1);
        check("sum0_err",  32'(error),  32'd0);
        check("sum0_lat",  32'(lat),    32'd18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
